reg_writeback_queue: RTL and testbench

// Writeback stage directly upstream of the register file write port. Buffers

---
 rtl/reg_writeback_queue.sv | 111 +++++++++++
 tb/tb_reg_writeback_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - writeback FIFO feeding the register file write port, with operand forwarding
module reg_writeback_queue #(
    parameter int DEPTH    = 2,
    parameter int ID_W     = 4,
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 13
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [ID_W-1:0]          i_in_id,
    input  logic [DATA_W-1:0]        i_in_value,
    input  logic                     i_wb_hold,
    output logic                     o_wb_valid,
    output logic [ID_W-1:0]          o_wb_id,
    output logic [DATA_W-1:0]        o_wb_value,
    input  logic [ID_W-1:0]          i_fwd1_id,
    output logic                     o_fwd1_hit,
    output logic [DATA_W-1:0]        o_fwd1_value,
    input  logic [ID_W-1:0]          i_fwd2_id,
    output logic                     o_fwd2_hit,
    output logic [DATA_W-1:0]        o_fwd2_value,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_bad_id
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ID_W-1:0]   r_id  [DEPTH];
    logic [DATA_W-1:0] r_val [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_bad_id;

    logic              w_push;
    logic              w_id_ok;
    logic              w_store;
    logic              w_pop;
    logic              w_empty;
    logic [PTR_W-1:0]  w_idx;

    assign w_empty    = (r_count == '0);
    assign o_in_ready = (r_count != CNT_W'(DEPTH));
    assign w_push     = i_in_valid & o_in_ready;
    assign w_id_ok    = (32'(i_in_id) < NUM_REGS);
    assign w_store    = w_push & w_id_ok;
    assign w_pop      = ~w_empty & ~i_wb_hold;

    assign o_wb_valid = w_pop;
    assign o_wb_id    = w_empty ? '0 : r_id[r_rd_ptr];
    assign o_wb_value = w_empty ? '0 : r_val[r_rd_ptr];
    assign o_count    = r_count;
    assign o_bad_id   = r_bad_id;

    // Walk oldest to youngest so a later match overrides an earlier one.
    always_comb begin
        o_fwd1_hit   = 1'b0;
        o_fwd1_value = '0;
        o_fwd2_hit   = 1'b0;
        o_fwd2_value = '0;
        w_idx        = r_rd_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_rd_ptr + PTR_W'(k);
            if (r_vld[w_idx] && r_id[w_idx] == i_fwd1_id) begin
                o_fwd1_hit   = 1'b1;
                o_fwd1_value = r_val[w_idx];
            end
            if (r_vld[w_idx] && r_id[w_idx] == i_fwd2_id) begin
                o_fwd2_hit   = 1'b1;
                o_fwd2_value = r_val[w_idx];
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_bad_id <= 1'b0;
            r_vld    <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_id[k]  <= '0;
                r_val[k] <= '0;
            end
        end else begin
            // A full queue never accepts, so write and read slots cannot collide here.
            if (w_store) begin
                r_id[r_wr_ptr]  <= i_in_id;
                r_val[r_wr_ptr] <= i_in_value;
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push && !w_id_ok) begin
                r_bad_id <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - self-checking bench for reg_writeback_queue
module tb_reg_writeback_queue;
    localparam int DEPTH    = 2;
    localparam int ID_W     = 4;
    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 13;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [ID_W-1:0]   in_id;
    logic [DATA_W-1:0] in_value;
    logic              wb_hold;
    logic              wb_valid;
    logic [ID_W-1:0]   wb_id;
    logic [DATA_W-1:0] wb_value;
    logic [ID_W-1:0]   fwd1_id;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_value;
    logic [ID_W-1:0]   fwd2_id;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_value;
    logic [CNT_W-1:0]  count;
    logic              bad_id;

    always #5 clk = ~clk;

    reg_writeback_queue #(
        .DEPTH(DEPTH), .ID_W(ID_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_in_id(in_id), .i_in_value(in_value),
        .i_wb_hold(wb_hold), .o_wb_valid(wb_valid), .o_wb_id(wb_id), .o_wb_value(wb_value),
        .i_fwd1_id(fwd1_id), .o_fwd1_hit(fwd1_hit), .o_fwd1_value(fwd1_value),
        .i_fwd2_id(fwd2_id), .o_fwd2_hit(fwd2_hit), .o_fwd2_value(fwd2_value),
        .o_count(count), .o_bad_id(bad_id)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] val;
    } ent_t;
    ent_t mq[$];
    bit   mbad = 1'b0;

    typedef struct {
        logic v; logic [3:0] id; logic [7:0] val; logic hold; logic [3:0] f1; logic [3:0] f2;
        logic e_rdy; logic e_wbv; logic [3:0] e_wbid; logic [7:0] e_wbval; logic [1:0] e_cnt;
        logic e_f1h; logic [7:0] e_f1v; logic e_f2h; logic [7:0] e_f2v; logic e_bad;
    } row_t;
    row_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] id, input logic [7:0] val,
                         input logic hold, input logic [3:0] f1, input logic [3:0] f2);
        @(negedge clk);
        in_valid = v; in_id = id; in_value = val; wb_hold = hold; fwd1_id = f1; fwd2_id = f2;
    endtask

    // Reference: queue of pending writes; expected outputs derived from queue contents.
    task automatic model_check();
        bit exp_wbv;
        bit f1h, f2h;
        logic [7:0] f1v, f2v;
        logic [3:0] hid;
        logic [7:0] hval;
        exp_wbv = (mq.size() != 0) && !wb_hold;
        hid  = (mq.size() != 0) ? mq[0].id  : 4'd0;
        hval = (mq.size() != 0) ? mq[0].val : 8'd0;
        f1h = 0; f2h = 0; f1v = 0; f2v = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].id == fwd1_id) begin f1h = 1; f1v = mq[i].val; end
            if (mq[i].id == fwd2_id) begin f2h = 1; f2v = mq[i].val; end
        end
        chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        chk("m_wb_valid", 32'(wb_valid), 32'(exp_wbv));
        chk("m_wb_id",    32'(wb_id),    32'(hid));
        chk("m_wb_value", 32'(wb_value), 32'(hval));
        chk("m_count",    32'(count),    32'(mq.size()));
        chk("m_fwd1_hit", 32'(fwd1_hit), 32'(f1h));
        chk("m_fwd1_val", 32'(fwd1_value), 32'(f1v));
        chk("m_fwd2_hit", 32'(fwd2_hit), 32'(f2h));
        chk("m_fwd2_val", 32'(fwd2_value), 32'(f2v));
        chk("m_bad_id",   32'(bad_id),   32'(mbad));
    endtask

    task automatic model_advance();
        bit pop, push;
        ent_t e;
        pop  = (mq.size() != 0) && !wb_hold;
        push = in_valid && (mq.size() != DEPTH);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (32'(in_id) < NUM_REGS) begin
                e.id = in_id; e.val = in_value;
                mq.push_back(e);
            end else begin
                mbad = 1'b1;
            end
        end
    endtask

    task automatic finish_cycle();
        model_check();
        model_advance();
        @(posedge clk);
    endtask

    task automatic rnd_cycle(input logic v, input logic [3:0] id, input logic hold);
        drive(v, id, 8'($urandom), hold, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)));
        #1;
        finish_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl = '{
            '{1'b1,4'h3,8'h5A,1'b0,4'h3,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h3,4'h0, 1'b1,1'b1,4'h3,8'h5A,2'd1,1'b1,8'h5A,1'b0,8'h00,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h3,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b1,4'h3,8'h11,1'b1,4'h3,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b1,4'h7,8'h22,1'b1,4'h3,4'h0, 1'b1,1'b0,4'h3,8'h11,2'd1,1'b1,8'h11,1'b0,8'h00,1'b0},
            '{1'b1,4'h3,8'h33,1'b1,4'h3,4'h0, 1'b0,1'b0,4'h3,8'h11,2'd2,1'b1,8'h11,1'b0,8'h00,1'b0},
            '{1'b1,4'h3,8'h33,1'b0,4'h3,4'h0, 1'b0,1'b1,4'h3,8'h11,2'd2,1'b1,8'h11,1'b0,8'h00,1'b0},
            '{1'b1,4'h3,8'h33,1'b0,4'h3,4'h0, 1'b1,1'b1,4'h7,8'h22,2'd1,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h3,4'h0, 1'b1,1'b1,4'h3,8'h33,2'd1,1'b1,8'h33,1'b0,8'h00,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h3,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b1,4'h5,8'hAA,1'b1,4'h0,4'h5, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b1,4'h5,8'hBB,1'b1,4'h0,4'h5, 1'b1,1'b0,4'h5,8'hAA,2'd1,1'b0,8'h00,1'b1,8'hAA,1'b0},
            '{1'b0,4'h0,8'h00,1'b1,4'h0,4'h5, 1'b0,1'b0,4'h5,8'hAA,2'd2,1'b0,8'h00,1'b1,8'hBB,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h0,4'h5, 1'b0,1'b1,4'h5,8'hAA,2'd2,1'b0,8'h00,1'b1,8'hBB,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h0,4'h5, 1'b1,1'b1,4'h5,8'hBB,2'd1,1'b0,8'h00,1'b1,8'hBB,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h0,4'h5, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b1,4'hE,8'hFF,1'b0,4'h0,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b0},
            '{1'b0,4'h0,8'h00,1'b0,4'h0,4'h0, 1'b1,1'b0,4'h0,8'h00,2'd0,1'b0,8'h00,1'b0,8'h00,1'b1}
        };

        rst = 1'b1; in_valid = 0; in_id = 0; in_value = 0; wb_hold = 0; fwd1_id = 3; fwd2_id = 0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_bad_id",   32'(bad_id),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].v, tbl[r].id, tbl[r].val, tbl[r].hold, tbl[r].f1, tbl[r].f2);
            #1;
            chk($sformatf("t%0d_in_ready", r), 32'(in_ready),   32'(tbl[r].e_rdy));
            chk($sformatf("t%0d_wb_valid", r), 32'(wb_valid),   32'(tbl[r].e_wbv));
            chk($sformatf("t%0d_wb_id", r),    32'(wb_id),      32'(tbl[r].e_wbid));
            chk($sformatf("t%0d_wb_value", r), 32'(wb_value),   32'(tbl[r].e_wbval));
            chk($sformatf("t%0d_count", r),    32'(count),      32'(tbl[r].e_cnt));
            chk($sformatf("t%0d_fwd1_hit", r), 32'(fwd1_hit),   32'(tbl[r].e_f1h));
            chk($sformatf("t%0d_fwd1_val", r), 32'(fwd1_value), 32'(tbl[r].e_f1v));
            chk($sformatf("t%0d_fwd2_hit", r), 32'(fwd2_hit),   32'(tbl[r].e_f2h));
            chk($sformatf("t%0d_fwd2_val", r), 32'(fwd2_value), 32'(tbl[r].e_f2v));
            chk($sformatf("t%0d_bad_id", r),   32'(bad_id),     32'(tbl[r].e_bad));
            finish_cycle();
        end

        // bad_id must stay set across further legal writes
        for (int i = 0; i < 10; i++) rnd_cycle(1'b1, 4'($urandom_range(12, 0)), 1'b0);
        for (int i = 0; i < 3; i++) rnd_cycle(1'b0, 4'h0, 1'b0);

        // Sit at DEPTH-1 entries with simultaneous push and pop
        rnd_cycle(1'b1, 4'h2, 1'b1);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 4'($urandom_range(12, 0)), 8'($urandom), 1'b0, 4'($urandom_range(15, 0)), 4'h0);
            #1;
            chk("t5_count_const", 32'(count), 32'(DEPTH - 1));
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) rnd_cycle(1'b1, 4'($urandom_range(12, 0)), 1'b1);

        // Asynchronous reset between edges with the queue full
        @(negedge clk);
        in_valid = 0; wb_hold = 1; fwd1_id = mq[0].id; fwd2_id = mq[1].id;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_wb_valid", 32'(wb_valid), 32'd0);
        chk("ar_wb_id",    32'(wb_id),    32'd0);
        chk("ar_wb_value", 32'(wb_value), 32'd0);
        chk("ar_count",    32'(count),    32'd0);
        chk("ar_fwd1_hit", 32'(fwd1_hit), 32'd0);
        chk("ar_fwd2_hit", 32'(fwd2_hit), 32'd0);
        chk("ar_bad_id",   32'(bad_id),   32'd0);
        mq.delete();
        mbad = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) rnd_cycle(1'b0, 4'h0, 1'b0);

        // Randomized traffic against the reference queue
        for (int i = 0; i < 300; i++) begin
            rnd_cycle(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), ($urandom_range(3, 0) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
